// File: rtl/dmem_stage_ctrl.sv
// dmem_stage_ctrl: multi-cycle data-memory controller for the memory stage.
// Accepts a load/store from the stage-3/4 buffer, stalls the pipeline while
// the fixed-latency array access is in flight, then strobes resp_valid for
// one cycle with rdata/err for the write-back mux.
// Optional macro DMEM_PERF_CNT_EN adds rd_count, wr_count and stall_count.
//
// state  | meaning
// IDLE   | no access in flight; a new request is accepted this cycle
// ACCESS | request captured; cnt counts down to the array operation
module dmem_stage_ctrl #(
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    input  logic        mem_rd,
    input  logic        mem_wr,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        stall,
    output logic        resp_valid,
    output logic [31:0] rdata,
    output logic        err,
    output logic        busy
`ifdef DMEM_PERF_CNT_EN
    ,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count,
    output logic [31:0] stall_count
`endif
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic {IDLE, ACCESS} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic        op_wr_q, op_wr_d;
    logic        resp_valid_q, resp_valid_d;
    logic        err_q, err_d;
    logic [31:0] rdata_q, rdata_d;

    logic [31:0] mem [DEPTH];

    logic          acc_req;
    logic          done;
    logic          in_range;
    logic          mem_we;
    logic [AW-1:0] idx;

    assign acc_req  = req_valid & (mem_rd | mem_wr);
    assign idx      = addr_q[AW-1:0];
    assign in_range = addr_q < 32'(DEPTH);
    assign done     = (state_q == ACCESS) && (cnt_q == 4'd0);
    // A write is committed only at the completing edge, so a reset that
    // lands mid-access discards it.
    assign mem_we   = done & op_wr_q & in_range;

    assign stall      = ((state_q == IDLE) & acc_req) | (state_q == ACCESS);
    assign busy       = (state_q != IDLE);
    assign resp_valid = resp_valid_q;
    assign rdata      = rdata_q;
    assign err        = err_q;

    // Next-state, request capture and response computation.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        op_wr_d      = op_wr_q;
        resp_valid_d = 1'b0;
        err_d        = 1'b0;
        rdata_d      = rdata_q;
        case (state_q)
            IDLE: begin
                if (acc_req) begin
                    addr_d  = addr;
                    wdata_d = wdata;
                    op_wr_d = mem_wr;   // rd+wr together is a write
                    cnt_d   = 4'(LATENCY - 1);
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    resp_valid_d = 1'b1;
                    err_d        = ~in_range;
                    rdata_d      = (!op_wr_q && in_range) ? mem[idx] : 32'd0;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Control and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            cnt_q        <= 4'd0;
            addr_q       <= 32'd0;
            wdata_q      <= 32'd0;
            op_wr_q      <= 1'b0;
            resp_valid_q <= 1'b0;
            err_q        <= 1'b0;
            rdata_q      <= 32'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            op_wr_q      <= op_wr_d;
            resp_valid_q <= resp_valid_d;
            err_q        <= err_d;
            rdata_q      <= rdata_d;
        end
    end

    // Data array write port; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[idx] <= wdata_q;
        end
    end

`ifdef DMEM_PERF_CNT_EN
    logic [31:0] rd_count_q, rd_count_d;
    logic [31:0] wr_count_q, wr_count_d;
    logic [31:0] stall_count_q, stall_count_d;

    // Performance counters; all wrap naturally at 2^32.
    always_comb begin
        rd_count_d    = rd_count_q;
        wr_count_d    = wr_count_q;
        stall_count_d = stall_count_q;
        if (done && in_range && !op_wr_q) rd_count_d = rd_count_q + 32'd1;
        if (mem_we)                       wr_count_d = wr_count_q + 32'd1;
        if (stall)                        stall_count_d = stall_count_q + 32'd1;
    end

    // Performance counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count_q    <= 32'd0;
            wr_count_q    <= 32'd0;
            stall_count_q <= 32'd0;
        end else begin
            rd_count_q    <= rd_count_d;
            wr_count_q    <= wr_count_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign rd_count    = rd_count_q;
    assign wr_count    = wr_count_q;
    assign stall_count = stall_count_q;
`endif

endmodule

// File: doc/dmem_stage_ctrl.md
Name: dmem_stage_ctrl

Overview:
- Multi-cycle data-memory controller for pipeline stage 4 (memory).
- Consumes the stage-3/4 buffer outputs (ALU result as address, store data, MemRd/MemWr) and owns a word-addressed data array with a fixed access latency.
- Stalls the pipeline while an access is in flight, then returns read data with a one-cycle response strobe to the write-back mux feeding the stage-4/5 buffer.

Parameters:
- DEPTH, 256: number of 32-bit words in the data array; power of two, 16..65536.
- LATENCY, 2: array access cycles per request; 1..15.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; asynchronous, active-low.
- req_valid  input  1  a stage-4 instruction is present this cycle.
- mem_rd  input  1  load request (MemRd).
- mem_wr  input  1  store request (MemWr).
- addr  input  32  word address (ALU result).
- wdata  input  32  store data.
- stall  output  1  hold PC, IR and all stage buffers this cycle.
- resp_valid  output  1  one-cycle strobe: access complete.
- rdata  output  32  load data; valid when resp_valid=1.
- err  output  1  one-cycle strobe with resp_valid: address out of range.
- busy  output  1  state != IDLE.

Behaviour:
- Interface: one clock, clk; reset rst_n is asynchronous and active-low.
- Reset values: state=IDLE, stall=0, resp_valid=0, rdata=0, err=0, busy=0, counter=0. Array contents are not reset.
- Access request: req_valid & (mem_rd | mem_wr).
- If mem_rd and mem_wr are both high, the request is treated as a write; no read data is returned (rdata=0).
- FSM IDLE:
  - On an access request, capture addr, wdata and op; load cnt=LATENCY-1; go to ACCESS.
  - A non-access req_valid is ignored: no stall, no response.
- FSM ACCESS:
  - If cnt != 0, decrement.
  - If cnt == 0, perform the array operation at this edge, register rdata/err, pulse resp_valid in the next cycle, and go to IDLE.
- stall (combinational) = (IDLE & access request) | ACCESS.
  - Stall is high from the request cycle through the final ACCESS cycle, i.e. LATENCY+1 cycles.
  - Stall is low in the resp_valid cycle, so the pipeline advances.
- Latency: with request in cycle 0, resp_valid is high in cycle LATENCY+1.
- Back-to-back: a new request in the resp_valid cycle is accepted; stall rises in that same cycle.
- Range check: index = addr[log2(DEPTH)-1:0]. The address is out of range if addr >= DEPTH.
  - Out-of-range write: the array is not modified.
  - Out-of-range read: rdata=0.
  - In both cases err=1 together with resp_valid.
- rdata holds its value until the next completed read. It is cleared to 0 on a write response.
- Inputs are sampled only at acceptance; changes during ACCESS are ignored.
- Reset asserted mid-access:
  - Immediate return to IDLE; all outputs go to their reset values.
  - A pending write is discarded (array unchanged). No response is issued.

Optional Feature:
- Macro: DMEM_PERF_CNT_EN.
- Defined:
  - Adds outputs rd_count[31:0], wr_count[31:0] and stall_count[31:0], all reset to 0.
  - rd_count and wr_count increment once per completed in-range read/write.
  - stall_count increments on every cycle with stall=1.
  - All three counters wrap modulo 2^32.
- Not defined: these ports and the counter logic are absent; all other behaviour is identical.

Test Plan:
- LATENCY=2: write addr=5, wdata=0xDEADBEEF in cycle 0 → stall=1 in cycles 0-2; resp_valid=1, err=0 in cycle 3; array[5]=0xDEADBEEF.
- Read addr=5 after the previous write → resp_valid in cycle 3 after request, rdata=0xDEADBEEF, 3 stall cycles total.
- Back-to-back: read addr=5 asserted in the resp_valid cycle of a prior write to addr=6 (0x12345678), then read addr=6 → second response rdata=0x12345678, no idle gap beyond the resp cycle.
- DEPTH=256: read addr=0x100 → resp_valid=1, err=1, rdata=0; write addr=0x1FF → err=1, array[0xFF] unchanged.
- rst_n low during ACCESS of write addr=7, wdata=0x55 → stall/busy/resp_valid drop immediately; array[7] retains its prior value; the next request behaves normally.
- mem_rd=mem_wr=1, addr=9, wdata=0xA5A5A5A5 → treated as a write: array[9]=0xA5A5A5A5, rdata=0. With DMEM_PERF_CNT_EN defined, wr_count increments by 1 and stall_count by LATENCY+1.
